dff_ram_param: RTL and testbench

//   Parametrised flip-flop RAM with active-low enable and write strobes, plus
//   per-byte write masking. Has a built-in clear sequencer that zeroes every

---
 rtl/dff_ram_param.sv | 81 ++++++++
 tb/tb_dff_ram_param.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/dff_ram_param.sv
// dff_ram_param: parametrised flip-flop RAM with byte-lane write mask and post-reset clear sequencer
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset; restarts the clear sequence
//   en_n       access enable, active low
//   wr_n       0 = write, 1 = read (when en_n = 0)
//   add        word address
//   wmask      per-lane write enable, bit i covers wdata[i*BYTE_W +: BYTE_W]
//   wdata      write data
//   rdata      registered read data
//   rvalid     one-cycle pulse, rdata was updated by a read
//   addr_err   one-cycle pulse, an accepted access had add >= DEPTH
//   init_busy  high while the memory is being cleared; accesses ignored
module dff_ram_param #(
    parameter int WIDTH  = 72,
    parameter int DEPTH  = 8,
    parameter int AW     = 3,
    parameter int BYTE_W = 8,
    localparam int NB    = WIDTH / BYTE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_n,
    input  logic              wr_n,
    input  logic [AW-1:0]     add,
    input  logic [NB-1:0]     wmask,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata,
    output logic              rvalid,
    output logic              addr_err,
    output logic              init_busy
);
    typedef enum logic {S_INIT, S_READY} state_t;
    state_t            r_state;
    state_t            w_next;
    logic [AW-1:0]     r_cnt;
    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic              w_acc;
    logic              w_inr;
    logic              w_wr;
    logic              w_rd;
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_INIT;
        else     r_state <= w_next;
    end
    always_comb begin
        w_next = (r_state == S_INIT && r_cnt == AW'(DEPTH - 1)) ? S_READY : r_state;
    end
    always_comb begin
        init_busy = (r_state == S_INIT);
    end
    assign w_acc = ~init_busy & ~en_n;
    assign w_inr = 32'(add) < DEPTH;
    assign w_wr  = w_acc & ~wr_n & w_inr;
    assign w_rd  = w_acc & wr_n;
    // Memory has no reset of its own; the INIT walk zeroes one word per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (init_busy) begin
            r_mem[r_cnt] <= '0;
            r_cnt        <= r_cnt + AW'(1);
        end else if (w_wr) begin
            for (int i = 0; i < NB; i++)
                if (wmask[i]) r_mem[add][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
        end
    end
    // Out-of-range reads still pulse rvalid but return zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata    <= '0;
            rvalid   <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            rvalid   <= w_rd;
            addr_err <= w_acc & ~w_inr;
            if (w_rd) rdata <= w_inr ? r_mem[add] : '0;
        end
    end
endmodule

// File: tb/tb_dff_ram_param.sv
// tb_dff_ram_param: randomized + directed bench with a behavioural model for two RAM sizes
module tb_dff_ram_param;
    logic        clk = 0;
    logic        rst = 0;
    logic        en_n = 1;
    logic        wr_n = 1;
    logic [2:0]  add = 0;
    logic [8:0]  wmask = 0;
    logic [71:0] wdata = 0;
    logic [71:0] rdata0, rdata1;
    logic        rvalid0, rvalid1, aerr0, aerr1, busy0, busy1;
    int          checks = 0;
    int          errors = 0;
    logic [71:0] mmem [2][8];
    logic [71:0] mrd [2];
    logic        mrv [2];
    logic        mae [2];
    int          mrem [2];
    logic        started = 0;

    always #5 clk = ~clk;

    dff_ram_param #(.DEPTH(8)) u8 (
        .clk(clk), .rst(rst), .en_n(en_n), .wr_n(wr_n), .add(add), .wmask(wmask),
        .wdata(wdata), .rdata(rdata0), .rvalid(rvalid0), .addr_err(aerr0), .init_busy(busy0));
    dff_ram_param #(.DEPTH(6)) u6 (
        .clk(clk), .rst(rst), .en_n(en_n), .wr_n(wr_n), .add(add), .wmask(wmask),
        .wdata(wdata), .rdata(rdata1), .rvalid(rvalid1), .addr_err(aerr1), .init_busy(busy1));

    task automatic chk(string name, logic [71:0] act, logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Model: a reset starts a DEPTH-cycle blackout after which memory reads as zero.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int d;
            d = (k == 0) ? 8 : 6;
            if (rst) begin
                started = 1;
                mrem[k] = d;
                mrd[k]  = 0;
                mrv[k]  = 0;
                mae[k]  = 0;
                for (int j = 0; j < 8; j++) mmem[k][j] = 0;
            end else if (mrem[k] > 0) begin
                mrem[k]--;
                mrv[k] = 0;
                mae[k] = 0;
            end else if (!en_n) begin
                mae[k] = int'(add) >= d;
                mrv[k] = wr_n;
                if (wr_n) mrd[k] = mae[k] ? 72'h0 : mmem[k][add];
                else if (!mae[k])
                    for (int l = 0; l < 9; l++)
                        if (wmask[l]) mmem[k][add][l*8 +: 8] = wdata[l*8 +: 8];
            end else begin
                mrv[k] = 0;
                mae[k] = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("rdata8", rdata0, mrd[0]);
            chk("rvalid8", 72'(rvalid0), 72'(mrv[0]));
            chk("addr_err8", 72'(aerr0), 72'(mae[0]));
            chk("init_busy8", 72'(busy0), 72'(mrem[0] > 0));
            chk("rdata6", rdata1, mrd[1]);
            chk("rvalid6", 72'(rvalid1), 72'(mrv[1]));
            chk("addr_err6", 72'(aerr1), 72'(mae[1]));
            chk("init_busy6", 72'(busy1), 72'(mrem[1] > 0));
        end
    end

    task automatic idle();
        @(negedge clk);
        en_n = 1; wr_n = 1; rst = 0;
    endtask
    task automatic wr(input logic [2:0] a, input logic [8:0] m, input logic [71:0] d);
        @(negedge clk);
        en_n = 0; wr_n = 0; add = a; wmask = m; wdata = d;
    endtask
    task automatic rd(input logic [2:0] a);
        @(negedge clk);
        en_n = 0; wr_n = 1; add = a;
    endtask
    // Call at the negedge where rst was just dropped; returns at first negedge with busy0 low.
    task automatic count_busy(output int n);
        n = 0;
        while (busy0 && n < 50) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        // Reset, with a write to word 2 held during INIT
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk("reset_rvalid", 72'(rvalid0), 72'h0);
        chk("reset_busy", 72'(busy0), 72'h1);
        rst = 0; en_n = 0; wr_n = 0; add = 2; wmask = 9'h1FF; wdata = '1;
        count_busy(n);
        chk("init_cycles", 72'(n), 72'd8);
        en_n = 1; wr_n = 1;
        // Clear check (word 2 must still be zero)
        for (int i = 0; i < 8; i++) begin
            rd(3'(i));
            idle();
            chk("clear_rdata", rdata0, 72'h0);
            chk("clear_rvalid", 72'(rvalid0), 72'h1);
        end
        // Full-word write and read
        wr(3, 9'h1FF, 72'hA5_0123_4567_89AB_CDEF);
        rd(3);
        idle();
        chk("full_rdata", rdata0, 72'hA5_0123_4567_89AB_CDEF);
        chk("full_rvalid", 72'(rvalid0), 72'h1);
        // Masked write, then no-op mask
        wr(3, 9'h001, '1);
        rd(3);
        idle();
        chk("mask_rdata", rdata0, 72'hA5_0123_4567_89AB_CDFF);
        wr(3, 9'h000, 72'h0);
        rd(3);
        rd(3);
        idle();
        chk("nomask_rdata", rdata0, 72'hA5_0123_4567_89AB_CDFF);
        // Out-of-range on DEPTH=6 instance
        wr(7, 9'h1FF, '1);
        idle();
        chk("oor_wr_aerr", 72'(aerr1), 72'h1);
        rd(7);
        idle();
        chk("oor_rd_aerr", 72'(aerr1), 72'h1);
        chk("oor_rd_rdata", rdata1, 72'h0);
        chk("oor_rd_rvalid", 72'(rvalid1), 72'h1);
        for (int i = 0; i < 6; i++) rd(3'(i));
        idle();
        // Reset during back-to-back reads
        wr(1, 9'h1FF, 72'h1);
        rd(1);
        rd(1);
        rst = 1;
        @(negedge clk);
        chk("rst_mid_rdata", rdata0, 72'h0);
        chk("rst_mid_rvalid", 72'(rvalid0), 72'h0);
        rst = 0; en_n = 1;
        count_busy(n);
        chk("reinit_cycles", 72'(n), 72'd8);
        rd(1);
        idle();
        chk("reinit_rdata", rdata0, 72'h0);
        chk("reinit_rvalid", 72'(rvalid0), 72'h1);
        // Random traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst   = ($urandom_range(0, 199) == 0);
            en_n  = ($urandom_range(0, 3) == 0);
            wr_n  = $urandom_range(0, 1);
            add   = 3'($urandom_range(0, 7));
            wmask = 9'($urandom_range(0, 511));
            wdata = 72'({$urandom, $urandom, $urandom});
        end
        idle();
        idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
